// File: rtl/program_counter.sv
// program_counter: fetch-address register with branch, call/return via a return-address stack,
// and a one-entry slot that holds control-flow requests arriving while pcEn is low.
module program_counter #(
   parameter int pcWidth = 8,
   parameter int stackDepth = 4,
   parameter logic [pcWidth-1:0] resetVector = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pcEn,
   input  logic               branchEn,
   input  logic               callEn,
   input  logic               retEn,
   input  logic [pcWidth-1:0] branchTarget,
   output logic [pcWidth-1:0] pc,
   output logic               branchPending,
   output logic               stackOverflow,
   output logic               stackUnderflow
);
   localparam int idxW = $clog2(stackDepth);
   localparam int cntW = idxW + 1;
   typedef enum logic [1:0] {reqNone, reqBranch, reqCall, reqRet} reqKind;
   logic [pcWidth-1:0] stack [stackDepth];
   logic [cntW-1:0] count;
   reqKind pendKind, newKind, effKind;
   logic [pcWidth-1:0] pendTarget, effTarget, pcNext, topEntry;
   logic stackFull, stackEmpty;
   always_comb begin
      newKind    = retEn ? reqRet : callEn ? reqCall : branchEn ? reqBranch : reqNone;
      effKind    = newKind != reqNone ? newKind : pendKind;
      effTarget  = newKind != reqNone ? branchTarget : pendTarget;
      pcNext     = pc + pcWidth'(1);
      stackFull  = count == cntW'(stackDepth);
      stackEmpty = count == '0;
      topEntry   = stack[idxW'(count - cntW'(1))];
   end
   assign branchPending = pendKind != reqNone;
   // A held call reuses pcNext at execution time; pc cannot move while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= resetVector;
         count          <= '0;
         pendKind       <= reqNone;
         pendTarget     <= '0;
         stackOverflow  <= 1'b0;
         stackUnderflow <= 1'b0;
      end else if (pcEn) begin
         pendKind <= reqNone;
         case (effKind)
            reqBranch: pc <= effTarget;
            reqCall: begin
               pc <= effTarget;
               if (stackFull) stackOverflow <= 1'b1;
               else begin
                  stack[count[idxW-1:0]] <= pcNext;
                  count                  <= count + cntW'(1);
               end
            end
            reqRet: begin
               if (stackEmpty) begin
                  pc             <= pcNext;
                  stackUnderflow <= 1'b1;
               end else begin
                  pc    <= topEntry;
                  count <= count - cntW'(1);
               end
            end
            default: pc <= pcNext;
         endcase
      end else if (newKind != reqNone) begin
         pendKind   <= newKind;
         pendTarget <= branchTarget;
      end
   end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: table-driven vectors with a scoreboard queue of expected outputs.
module tb_program_counter;
   logic clk = 1'b0;
   logic reset = 1'b1, pcEn = 1'b0, branchEn = 1'b0, callEn = 1'b0, retEn = 1'b0;
   logic [7:0] branchTarget = '0;
   logic [7:0] pc;
   logic branchPending, stackOverflow, stackUnderflow;
   int checks = 0, errors = 0;

   typedef struct {
      logic rs, en, br, ca, rt;
      logic [7:0] tgt, ePc;
      logic ePend, eOvf, eUnf;
   } vec_t;

   vec_t vecs[$];
   vec_t expQ[$];

   program_counter #(.pcWidth(8), .stackDepth(4), .resetVector(8'h00)) dut (
      .clk(clk), .reset(reset), .pcEn(pcEn), .branchEn(branchEn), .callEn(callEn),
      .retEn(retEn), .branchTarget(branchTarget), .pc(pc), .branchPending(branchPending),
      .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int rs, int en, int br, int ca, int rt, int tgt,
                               int ePc, int ePend, int eOvf, int eUnf);
      vec_t v;
      v.rs = rs[0]; v.en = en[0]; v.br = br[0]; v.ca = ca[0]; v.rt = rt[0];
      v.tgt = tgt[7:0]; v.ePc = ePc[7:0];
      v.ePend = ePend[0]; v.eOvf = eOvf[0]; v.eUnf = eUnf[0];
      return v;
   endfunction

   task automatic check(input string tag, input string what, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, what, act, req);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      reset = v.rs; pcEn = v.en; branchEn = v.br; callEn = v.ca; retEn = v.rt;
      branchTarget = v.tgt;
      expQ.push_back(v);
      @(posedge clk); #1;
      if (expQ.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: queue empty", tag);
      end else begin
         e = expQ.pop_front();
         check(tag, "pc", int'(pc), int'(e.ePc));
         check(tag, "branchPending", int'(branchPending), int'(e.ePend));
         check(tag, "stackOverflow", int'(stackOverflow), int'(e.eOvf));
         check(tag, "stackUnderflow", int'(stackUnderflow), int'(e.eUnf));
      end
   endtask

   initial begin
      // reset, then 259 enabled cycles wrapping through 255 -> 0
      vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,0,0));
      for (int i = 1; i < 260; i++) vecs.push_back(mk(0,1,0,0,0,0, i % 256,0,0,0));
      // nested call/return
      vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,0,0));
      for (int i = 1; i <= 5; i++) vecs.push_back(mk(0,1,0,0,0,0, i,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h20, 8'h20,0,0,0));
      vecs.push_back(mk(0,1,0,0,0,0, 8'h21,0,0,0));
      vecs.push_back(mk(0,1,0,0,0,0, 8'h22,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h30, 8'h30,0,0,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h23,0,0,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h06,0,0,0));
      // overflow then underflow
      vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h10, 8'h10,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h20, 8'h20,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h30, 8'h30,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h40, 8'h40,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h50, 8'h50,0,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h31,0,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h21,0,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h11,0,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h01,0,1,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h02,0,1,1));
      // simultaneous requests: return wins, no push
      vecs.push_back(mk(1,0,0,0,0,0, 8'h00,0,0,0));
      for (int i = 1; i <= 16; i++) vecs.push_back(mk(0,1,0,0,0,0, i,0,0,0));
      vecs.push_back(mk(0,1,0,1,0,8'h50, 8'h50,0,0,0));
      vecs.push_back(mk(0,1,1,1,1,8'h80, 8'h11,0,0,0));
      vecs.push_back(mk(0,1,0,0,1,0, 8'h12,0,0,1));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

      // branch captured during a stall
      apply(mk(1,0,0,0,0,0, 8'h00,0,0,0), "stall_reset");
      for (int i = 1; i <= 10; i++) apply(mk(0,1,0,0,0,0, i,0,0,0), "stall_inc");
      apply(mk(0,0,0,0,0,0, 8'h0a,0,0,0), "stall1");
      apply(mk(0,0,1,0,0,8'h40, 8'h0a,1,0,0), "stall2");
      apply(mk(0,0,0,0,0,0, 8'h0a,1,0,0), "stall3");
      apply(mk(0,1,0,0,0,0, 8'h40,0,0,0), "stall_apply");
      apply(mk(0,1,0,0,0,0, 8'h41,0,0,0), "stall_next");

      // pending overwritten by a call; held call pushes pc+1
      apply(mk(1,0,0,0,0,0, 8'h00,0,0,0), "ovw_reset");
      apply(mk(0,1,0,0,0,0, 8'h01,0,0,0), "ovw_inc");
      apply(mk(0,0,1,0,0,8'h70, 8'h01,1,0,0), "ovw_branch");
      apply(mk(0,0,0,1,0,8'h60, 8'h01,1,0,0), "ovw_call");
      apply(mk(0,1,0,0,0,0, 8'h60,0,0,0), "ovw_apply");
      apply(mk(0,1,0,0,1,0, 8'h02,0,0,0), "ovw_ret");

      // reset during a stall discards the pending branch
      apply(mk(1,0,0,0,0,0, 8'h00,0,0,0), "rms_reset");
      apply(mk(0,1,0,0,0,0, 8'h01,0,0,0), "rms_inc");
      apply(mk(0,0,1,0,0,8'h77, 8'h01,1,0,0), "rms_capture");
      apply(mk(1,0,0,0,0,0, 8'h00,0,0,0), "rms_reset2");
      apply(mk(0,1,0,0,0,0, 8'h01,0,0,0), "rms_after1");
      apply(mk(0,1,0,0,0,0, 8'h02,0,0,0), "rms_after2");

      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/program_counter.md
# program_counter

Program counter stage directly downstream of the delay counter: consumes its `pcEn` stall gate and produces the instruction-fetch address. Each enabled cycle it advances the PC, takes a branch, performs a call (pushing the return address onto an internal return-address stack) or a return (popping it). Control-flow requests that arrive while `pcEn` is low are held in a one-entry pending slot and applied on the first enabled cycle.

## Interface
- `pcWidth`, 8: width of PC, branch target and stack entries.
- `stackDepth`, 4: return-address stack entries (power of two, ≥2).
- `resetVector`, 0: PC value after reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `pcEn`  in  1  advance permission from delay counter; 0 = hold PC.
- `branchEn`  in  1  one-cycle pulse: jump to `branchTarget`.
- `callEn`  in  1  one-cycle pulse: push PC+1, jump to `branchTarget`.
- `retEn`  in  1  one-cycle pulse: pop stack into PC.
- `branchTarget`  in  pcWidth  target for branch/call, sampled with the request.
- `pc`  out  pcWidth  current fetch address (registered).
- `branchPending`  out  1  pending slot occupied.
- `stackOverflow`  out  1  sticky: call issued with stack full.
- `stackUnderflow`  out  1  sticky: return issued with stack empty.

## Operation
- Reset (sampled at edge): `pc`=resetVector, stack count=0, pending cleared, both flags cleared, `branchPending`=0. Reset overrides all other inputs.
- Request priority within a cycle: `retEn` > `callEn` > `branchEn`; lower-priority requests that cycle are discarded.
- Effective request: a new request this cycle if any, else the pending slot content (new request overwrites pending — last request wins).
- `pcEn`=1:
  - none: `pc` ← `pc`+1, modulo 2^pcWidth (wraps from all-ones to 0).
  - branch: `pc` ← target.
  - call, stack not full: push `pc`+1 (modulo), `pc` ← target.
  - call, stack full: `pc` ← target, push discarded (existing entries unchanged), `stackOverflow` ← 1.
  - return, stack not empty: `pc` ← top entry, pop.
  - return, stack empty: `pc` ← `pc`+1, `stackUnderflow` ← 1.
  - pending slot cleared.
- `pcEn`=0: `pc` and stack hold. A new request (after priority) is stored in the pending slot as {kind, target}, replacing any previous pending entry. No request: slot unchanged.
- Pending-slot call pushes `pc`+1 computed from `pc` at the time it executes (PC was held, so equal to capture-time value).
- Stack: LIFO, count 0..stackDepth; full = count==stackDepth, empty = count==0.
- Flags clear only on reset.

## Timing
- Single-cycle latency: request/pcEn sampled at edge n, new `pc` visible after edge n.
- `branchPending` rises after the edge that captures a request with `pcEn`=0; falls after the edge where `pcEn`=1 applies it.
- `pcEn` held low for k cycles: `pc` constant for those k edges; first enabled edge applies pending or increments.
- Flags assert after the edge of the offending request; no combinational paths from inputs to outputs.
- Reset mid-stall: pending request discarded, not executed after reset.

## Test plan
- Reset then `pcEn`=1 for 260 cycles (pcWidth=8): `pc` 0,1,…,255,0,1,2,3; no flags.
- `pc`=10, `pcEn`=0 for 3 cycles, `branchEn` pulse with target 0x40 in 2nd stall cycle: `pc` stays 10, `branchPending`=1; first enabled edge → `pc`=0x40, `branchPending`=0; next → 0x41.
- Call target 0x20 at `pc`=5, then call 0x30 at `pc`=0x22, then two returns: `pc` 0x20…0x30…→0x23→6.
- Five calls with stackDepth=4 without returns: `stackOverflow`=1 after 5th; four returns restore the first four return addresses in reverse order; a fifth return sets `stackUnderflow`=1 and increments `pc`.
- `retEn`, `callEn`, `branchEn` together with one entry (0x11) on stack, target 0x80: `pc`=0x11, stack empty, no push.
- Branch captured during stall, then `reset` asserted before `pcEn` returns: `pc`=resetVector, `branchPending`=0, next enabled cycles count resetVector+1, +2 with no jump.
